// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl: fetch sequencer for the instruction SRAM feeding ICache.
// Ports: clk/rst (sync, active-high); iRedirectVld/iRedirectPc redirect;
//   oInsCen/oInsAddr/iInsData SRAM read port (1-cycle latency);
//   oRstingBlk ICache pass mask; oInsVld/oIns/oPc/iDecRdy decode handshake.
module icache_fetch_ctrl #(
  parameter int unsigned CACHE_WIDTHE   = 5,
  parameter int unsigned CACHE_DEEPTHE  = 12,
  parameter logic [31:0] RESET_PC       = 32'h0,
  parameter int unsigned RST_BLK_CYCLES = 4,
  localparam int unsigned DW = 2**CACHE_WIDTHE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iRedirectVld,
  input  logic [31:0]              iRedirectPc,
  output logic                     oInsCen,
  output logic [CACHE_DEEPTHE-1:0] oInsAddr,
  input  logic [DW-1:0]            iInsData,
  output logic                     oRstingBlk,
  output logic                     oInsVld,
  output logic [DW-1:0]            oIns,
  output logic [31:0]              oPc,
  input  logic                     iDecRdy
);

  typedef enum logic {
    BLOCK,
    RUN
  } state_e;

  localparam logic [3:0]  BLK_LAST = 4'(RST_BLK_CYCLES - 1);
  localparam logic [31:0] PC_INIT  = {RESET_PC[31:2], 2'b00};

  state_e          state_q, state_d;
  logic [3:0]      blk_cnt_q, blk_cnt_d;
  logic [31:0]     pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     tag_q, tag_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [DW-1:0]   ins0_q, ins0_d;
  logic [DW-1:0]   ins1_q, ins1_d;
  logic [31:0]     pc0_q, pc0_d;
  logic [31:0]     pc1_q, pc1_d;
  logic [31:0]     opc_q, opc_d;

  logic            run;
  logic            head_vld;
  logic            pop;
  logic            push;
  logic            issue;
  logic [1:0]      wr_slot;
  logic [31:0]     redir_pc;
  logic            unused_redir_lsb;

  assign unused_redir_lsb = ^iRedirectPc[1:0];
  assign redir_pc = {iRedirectPc[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    blk_cnt_d  = blk_cnt_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    ins0_d     = ins0_q;
    ins1_d     = ins1_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;

    run      = (state_q == RUN);
    head_vld = (cnt_q != 2'd0);
    oInsVld  = head_vld & ~iRedirectVld;
    pop      = oInsVld & iDecRdy;
    push     = run & inflight_q & ~iRedirectVld;
    // Credit: buffered + in flight - leaving must leave room for one more.
    issue    = run & ~iRedirectVld &
               (({1'b0, cnt_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
    wr_slot  = cnt_q - {1'b0, pop};

    oInsCen    = issue;
    oInsAddr   = run ? pc_q[CACHE_DEEPTHE+1:2] : '0;
    oRstingBlk = run;
    oIns       = head_vld ? (ins0_q & {DW{run}}) : '0;
    oPc        = head_vld ? pc0_q : opc_q;
    opc_d      = oPc;

    unique case (state_q)
      BLOCK: begin
        blk_cnt_d = blk_cnt_q + 4'd1;
        if (blk_cnt_q == BLK_LAST) begin
          state_d = RUN;
        end
        if (iRedirectVld) begin
          pc_d = redir_pc;
        end
      end
      RUN: begin
        if (iRedirectVld) begin
          pc_d       = redir_pc;
          inflight_d = 1'b0;
          cnt_d      = 2'd0;
        end else begin
          inflight_d = issue;
          if (issue) begin
            pc_d  = pc_q + 32'd4;
            tag_d = pc_q;
          end
          if (pop) begin
            ins0_d = ins1_q;
            pc0_d  = pc1_q;
          end
          if (push) begin
            if (wr_slot == 2'd0) begin
              ins0_d = iInsData;
              pc0_d  = tag_q;
            end else begin
              ins1_d = iInsData;
              pc1_d  = tag_q;
            end
          end
          cnt_d = cnt_q - {1'b0, pop} + {1'b0, push};
        end
      end
      default: state_d = BLOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BLOCK;
      blk_cnt_q  <= '0;
      pc_q       <= PC_INIT;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      cnt_q      <= '0;
      ins0_q     <= '0;
      ins1_q     <= '0;
      pc0_q      <= '0;
      pc1_q      <= '0;
      opc_q      <= '0;
    end else begin
      state_q    <= state_d;
      blk_cnt_q  <= blk_cnt_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      ins0_q     <= ins0_d;
      ins1_q     <= ins1_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
      opc_q      <= opc_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && cnt_q == 2'd2))
        else $error("icache_fetch_ctrl: buffer overflow");
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// tb_icache_fetch_ctrl: directed + random stimulus against a PC-order
// reference model of the fetch stream.
module tb_icache_fetch_ctrl;

  localparam int          BLK = 4;
  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        iRedirectVld;
  logic [31:0] iRedirectPc;
  logic        oInsCen;
  logic [11:0] oInsAddr;
  logic [31:0] iInsData;
  logic        oRstingBlk;
  logic        oInsVld;
  logic [31:0] oIns;
  logic [31:0] oPc;
  logic        iDecRdy;

  icache_fetch_ctrl #(
    .CACHE_WIDTHE(5),
    .CACHE_DEEPTHE(12),
    .RESET_PC(RPC),
    .RST_BLK_CYCLES(BLK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .iRedirectVld(iRedirectVld),
    .iRedirectPc(iRedirectPc),
    .oInsCen(oInsCen),
    .oInsAddr(oInsAddr),
    .iInsData(iInsData),
    .oRstingBlk(oRstingBlk),
    .oInsVld(oInsVld),
    .oIns(oIns),
    .oPc(oPc),
    .iDecRdy(iDecRdy)
  );

  always #5 clk = ~clk;

  // SRAM: word k holds k; dout is garbage on cycles without a read
  logic [31:0] sram_q;
  always @(posedge clk) begin
    if (oInsCen) sram_q <= 32'(oInsAddr);
    else         sram_q <= $urandom;
  end
  assign iInsData = sram_q;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_pc;
  int          since_rst;
  int          starve;
  bit          redir_prev;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the negedge: check this cycle against the model, then
  // advance the model and move to just after the next posedge.
  task automatic fin();
    if (since_rst < BLK) begin
      chk("blk_mask", 32'(oRstingBlk), 0);
      chk("blk_cen", 32'(oInsCen), 0);
    end else begin
      chk("run_mask", 32'(oRstingBlk), 1);
    end
    if (redir_prev) chk("redir_n1_vld", 32'(oInsVld), 0);
    if (iRedirectVld) begin
      chk("redir_vld", 32'(oInsVld), 0);
    end else if (oInsVld && iDecRdy) begin
      chk("acc_pc", oPc, exp_pc);
      chk("acc_ins", oIns, 32'(exp_pc[13:2]));
      exp_pc = exp_pc + 32'd4;
      starve = 0;
    end else if (iDecRdy) begin
      starve++;
    end
    chk("liveness", 32'(starve <= 7), 1);
    redir_prev = iRedirectVld;
    if (iRedirectVld) begin
      exp_pc = {iRedirectPc[31:2], 2'b00};
      starve = 0;
    end
    if (rst) begin
      exp_pc     = RPC;
      since_rst  = 0;
      starve     = 0;
      redir_prev = 0;
    end else if (since_rst < BLK) begin
      since_rst++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    fin();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cen"}, 32'(oInsCen), 0);
    chk({tag, "_addr"}, 32'(oInsAddr), 0);
    chk({tag, "_mask"}, 32'(oRstingBlk), 0);
    chk({tag, "_vld"}, 32'(oInsVld), 0);
    chk({tag, "_ins"}, oIns, 0);
    chk({tag, "_pc"}, oPc, 0);
  endtask

  initial begin
    rst = 1'b1;
    iDecRdy = 1'b1;
    iRedirectVld = 1'b0;
    iRedirectPc = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = RPC;
    since_rst = 0;
    starve = 0;
    redir_prev = 0;

    // reset and BLOCK window, first fetch
    @(negedge clk);
    chk_reset_outs("rst");
    fin();
    for (int c = 2; c <= 4; c++) cyc();
    @(negedge clk);
    chk("first_cen", 32'(oInsCen), 1);
    chk("first_addr", 32'(oInsAddr), 32'h40);
    fin();
    @(negedge clk);
    chk("c6_vld", 32'(oInsVld), 0);
    fin();
    @(negedge clk);
    chk("c7_vld", 32'(oInsVld), 1);
    chk("c7_pc", oPc, RPC);
    fin();

    // streaming
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_vld", 32'(oInsVld), 1);
      fin();
    end

    // backpressure
    iDecRdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_vld", 32'(oInsVld), 1);
      chk("bp_head", oPc, exp_pc);
      chk("bp_cen", 32'(oInsCen), 0);
      fin();
    end
    iDecRdy = 1'b1;
    repeat (6) cyc();

    // redirect with a full buffer
    iDecRdy = 1'b0;
    repeat (3) cyc();
    iDecRdy = 1'b1;
    iRedirectVld = 1'b1;
    iRedirectPc = 32'h203;
    cyc();
    iRedirectVld = 1'b0;
    @(negedge clk);
    chk("rd_n1_cen", 32'(oInsCen), 1);
    chk("rd_n1_addr", 32'(oInsAddr), 32'h80);
    fin();
    @(negedge clk);
    chk("rd_n2_vld", 32'(oInsVld), 0);
    fin();
    @(negedge clk);
    chk("rd_n3_vld", 32'(oInsVld), 1);
    chk("rd_n3_pc", oPc, 32'h200);
    fin();
    repeat (4) cyc();

    // reset pulse with a full buffer
    iDecRdy = 1'b0;
    repeat (3) cyc();
    iDecRdy = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("midrst");
    fin();
    repeat (8) cyc();

    // redirect during BLOCK
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    iRedirectVld = 1'b1;
    iRedirectPc = 32'h40;
    cyc();
    iRedirectVld = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    chk("blkrd_cen", 32'(oInsCen), 1);
    chk("blkrd_addr", 32'(oInsAddr), 32'h10);
    fin();
    repeat (4) cyc();

    // PC and address wrap
    iRedirectVld = 1'b1;
    iRedirectPc = 32'hFFFF_FFF9;
    cyc();
    iRedirectVld = 1'b0;
    repeat (8) cyc();

    // reset beats a simultaneous redirect
    rst = 1'b1;
    iRedirectVld = 1'b1;
    iRedirectPc = 32'h5000;
    cyc();
    rst = 1'b0;
    iRedirectVld = 1'b0;
    repeat (10) cyc();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      iDecRdy = ($urandom_range(0, 3) != 0);
      if (!iRedirectVld && $urandom_range(0, 19) == 0) begin
        iRedirectVld = 1'b1;
        iRedirectPc = $urandom;
      end else begin
        iRedirectVld = 1'b0;
      end
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0;
    iRedirectVld = 1'b0;
    iDecRdy = 1'b1;
    repeat (10) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
